// File: rtl/alu_iter_pkg.sv
// Shared types and helpers for the iterative accumulator ALU.
package alu_iter_pkg;

    typedef enum logic {IDLE, MUL} state_t;

    // Results are fitted from a 64-bit signed intermediate, so WIDTH must stay <= 32.
    localparam int MAX_W = 32;

    typedef struct packed {
        logic              ovf;
        logic signed [63:0] val;
    } fit_t;

    // Iteration counter width for a WIDTH-step multiply.
    function automatic int cnt_w(int width);
        return $clog2(width + 1);
    endfunction

    // Fit a wide signed value into a signed 'width' range: clamp when sat is set,
    // otherwise pass through so the caller keeps the low bits. ovf flags out-of-range.
    function automatic fit_t sat_fit(logic signed [63:0] value, int width, bit sat);
        fit_t   r;
        longint hi;
        longint lo;
        hi    = (longint'(1) <<< (width - 1)) - 1;
        lo    = -(longint'(1) <<< (width - 1));
        r.ovf = (value > hi) || (value < lo);
        r.val = value;
        if (sat && (value > hi))
            r.val = hi;
        else if (sat && (value < lo))
            r.val = lo;
        return r;
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Operand, strobe and result bundle between decoder/regfile and the ALU.
interface alu_iter_if #(parameter int WIDTH = 8);
    logic signed [WIDTH-1:0] Imm;
    logic        [WIDTH-1:0] RegData;
    logic        [WIDTH-1:0] SW;
    logic                    SelSW;
    logic                    SelImm;
    logic                    UseMul;
    logic                    UseACC;
    logic                    WE;
    logic                    ClrOvf;
    logic                    Busy;
    logic                    Done;
    logic                    Ovf;
    logic signed [WIDTH-1:0] ACC;

    modport master (output Imm, RegData, SW, SelSW, SelImm, UseMul, UseACC, WE, ClrOvf,
                    input  Busy, Done, Ovf, ACC);
    modport slave  (input  Imm, RegData, SW, SelSW, SelImm, UseMul, UseACC, WE, ClrOvf,
                    output Busy, Done, Ovf, ACC);
endinterface

// File: rtl/alu_iter_seq_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Done and Prod are combinational: they are valid in the cycle whose closing
// edge retires the final iteration, so the caller can capture on that edge.
module seq_mul
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Prod
);
    localparam int CNT_W = cnt_w(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] psum;
    logic [2*WIDTH-1:0] psum_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    assign psum_nxt = mplier[0] ? psum + mcand : psum;
    assign Prod     = psum_nxt;
    assign Done     = Busy && (cnt == CNT_W'(WIDTH - 1));

    // Latch operands on Start, then add-and-shift once per cycle for WIDTH cycles.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mcand  <= '0;
            psum   <= '0;
            mplier <= '0;
            cnt    <= '0;
            Busy   <= 1'b0;
        end else if (Start && !Busy) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            psum   <= '0;
            mplier <= B;
            cnt    <= '0;
            Busy   <= 1'b1;
        end else if (Busy) begin
            psum   <= psum_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (Done)
                Busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_iter.sv
// Accumulator ALU: single-cycle add/load, iterative fixed-point multiply,
// optional saturation and a sticky overflow flag.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 3,
    parameter int SAT   = 1
) (
    input logic       Clock,
    input logic       Reset,
    alu_iter_if.slave bus
);
    state_t                  state, state_nxt;
    logic signed [WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0] opd;
    logic signed [WIDTH-1:0] opa;
    logic        [WIDTH-1:0] mag_a;
    logic        [WIDTH-1:0] mag_b;
    logic        [2*WIDTH-1:0] uprod;
    logic signed [WIDTH:0]   sum;
    logic signed [2*WIDTH:0] sprod;
    logic signed [2*WIDTH:0] pshift;
    logic signed [63:0]      fit_in;
    logic        [WIDTH-1:0] acc_fit;
    logic                    fit_ovf;
    logic                    start, add_go, upd;
    logic                    mul_busy, mul_done;
    logic                    neg_q, done_q, ovf_q;

    assign opd   = bus.SelSW ? bus.SW : (bus.SelImm ? bus.Imm : bus.RegData);
    assign opa   = bus.UseACC ? acc_q : '0;
    // Magnitudes are unsigned, so -2^(WIDTH-1) maps cleanly to 2^(WIDTH-1).
    assign mag_a = opa[WIDTH-1] ? -opa : opa;
    assign mag_b = bus.Imm[WIDTH-1] ? -bus.Imm : bus.Imm;

    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .Clock (Clock),
        .Reset (Reset),
        .Start (start),
        .A     (mag_a),
        .B     (mag_b),
        .Busy  (mul_busy),
        .Done  (mul_done),
        .Prod  (uprod)
    );

    assign sum    = (WIDTH+1)'(opa) + (WIDTH+1)'(opd);
    assign sprod  = neg_q ? -$signed({1'b0, uprod}) : $signed({1'b0, uprod});
    assign pshift = sprod >>> FRAC;
    assign fit_in = add_go ? longint'(sum) : longint'(pshift);
    // The fitted value sits in the low bits of the struct, the flag in its MSB.
    assign acc_fit = WIDTH'(sat_fit(fit_in, WIDTH, SAT != 0));
    assign fit_ovf = 1'(sat_fit(fit_in, WIDTH, SAT != 0) >> 64);
    assign upd     = add_go || mul_done;

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and issue strobes; WE is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        add_go    = 1'b0;
        case (state)
            IDLE: if (bus.WE) begin
                if (bus.UseMul) begin
                    start     = 1'b1;
                    state_nxt = MUL;
                end else begin
                    add_go = 1'b1;
                end
            end
            MUL: if (mul_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, result pulse, product sign and sticky overflow (set beats clear).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            done_q <= upd;
            if (upd)
                acc_q <= acc_fit;
            if (upd && fit_ovf)
                ovf_q <= 1'b1;
            else if (bus.ClrOvf)
                ovf_q <= 1'b0;
            if (start)
                neg_q <= opa[WIDTH-1] ^ bus.Imm[WIDTH-1];
        end
    end

    assign bus.Busy = mul_busy;
    assign bus.Done = done_q;
    assign bus.Ovf  = ovf_q;
    assign bus.ACC  = acc_q;
endmodule

// File: tb/tb_alu_iter.sv
// Directed bench: a saturating and a wrapping instance share one stimulus.
module tb_alu_iter;
    localparam int W = 8;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 Clock = ~Clock;

    alu_iter_if #(.WIDTH(W)) bs();
    alu_iter_if #(.WIDTH(W)) bw();

    assign bw.Imm     = bs.Imm;
    assign bw.RegData = bs.RegData;
    assign bw.SW      = bs.SW;
    assign bw.SelSW   = bs.SelSW;
    assign bw.SelImm  = bs.SelImm;
    assign bw.UseMul  = bs.UseMul;
    assign bw.UseACC  = bs.UseACC;
    assign bw.WE      = bs.WE;
    assign bw.ClrOvf  = bs.ClrOvf;

    alu_iter #(.WIDTH(W), .FRAC(3), .SAT(1)) dut_s (.Clock(Clock), .Reset(Reset), .bus(bs));
    alu_iter #(.WIDTH(W), .FRAC(3), .SAT(0)) dut_w (.Clock(Clock), .Reset(Reset), .bus(bw));

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_in();
        bs.WE     = 1'b0;
        bs.UseMul = 1'b0;
        bs.UseACC = 1'b0;
        bs.SelSW  = 1'b0;
        bs.SelImm = 1'b0;
        bs.ClrOvf = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v);
        bs.SelSW  = 1'b1;
        bs.SW     = v;
        bs.UseACC = 1'b0;
        bs.UseMul = 1'b0;
        bs.WE     = 1'b1;
        tick();
        idle_in();
    endtask

    task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] imm,
                       input logic [W-1:0] es, input logic [W-1:0] ew,
                       input logic eos, input logic eow, input bit disturb);
        load(a);
        bs.UseACC = 1'b1;
        bs.UseMul = 1'b1;
        bs.Imm    = imm;
        bs.WE     = 1'b1;
        tick();
        idle_in();
        chk({tag, "_busy0"}, W'(bs.Busy), 8'h01);
        chk({tag, "_done0"}, W'(bs.Done), 8'h00);
        for (int i = 1; i <= 7; i++) begin
            if (disturb && i == 3) begin
                bs.WE      = 1'b1;
                bs.UseMul  = 1'b0;
                bs.UseACC  = 1'b1;
                bs.RegData = 8'h33;
                bs.Imm     = 8'h55;
            end
            tick();
            idle_in();
            chk({tag, "_busy"}, W'(bs.Busy), 8'h01);
            chk({tag, "_hold"}, bs.ACC, a);
        end
        tick();
        chk({tag, "_acc_s"}, bs.ACC, es);
        chk({tag, "_acc_w"}, bw.ACC, ew);
        chk({tag, "_busy_end"}, W'(bs.Busy), 8'h00);
        chk({tag, "_done"}, W'(bs.Done), 8'h01);
        chk({tag, "_ovf_s"}, W'(bs.Ovf), W'(eos));
        chk({tag, "_ovf_w"}, W'(bw.Ovf), W'(eow));
        tick();
        chk({tag, "_done_pulse"}, W'(bs.Done), 8'h00);
    endtask

    initial begin
        idle_in();
        bs.Imm     = '0;
        bs.RegData = '0;
        bs.SW      = '0;
        tick();
        tick();
        chk("rst_acc", bs.ACC, 8'h00);
        chk("rst_busy", W'(bs.Busy), 8'h00);
        chk("rst_done", W'(bs.Done), 8'h00);
        chk("rst_ovf", W'(bs.Ovf), 8'h00);
        Reset = 1'b0;
        tick();

        // Load from switches, then accumulate a register operand.
        load(8'h14);
        chk("ld_acc", bs.ACC, 8'h14);
        chk("ld_done", W'(bs.Done), 8'h01);
        chk("ld_busy", W'(bs.Busy), 8'h00);
        tick();
        chk("ld_done_pulse", W'(bs.Done), 8'h00);
        chk("ld_hold", bs.ACC, 8'h14);
        bs.RegData = 8'h05;
        bs.UseACC  = 1'b1;
        bs.WE      = 1'b1;
        tick();
        idle_in();
        chk("add_acc", bs.ACC, 8'h19);

        // Fixed-point multiplies (FRAC=3).
        mul("m_pos",   8'h10, 8'h0C, 8'h18, 8'h18, 1'b0, 1'b0, 1'b0);
        mul("m_neg",   8'hF0, 8'h0C, 8'hE8, 8'hE8, 1'b0, 1'b0, 1'b0);
        mul("m_floor", 8'hFF, 8'h01, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        mul("m_min",   8'h08, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);

        // Add overflow: clamp vs wrap, sticky, clear, set beats clear.
        load(8'h7F);
        bs.RegData = 8'h01;
        bs.UseACC  = 1'b1;
        bs.WE      = 1'b1;
        tick();
        idle_in();
        chk("ovf_acc_s", bs.ACC, 8'h7F);
        chk("ovf_acc_w", bw.ACC, 8'h80);
        chk("ovf_s", W'(bs.Ovf), 8'h01);
        chk("ovf_w", W'(bw.Ovf), 8'h01);
        tick();
        chk("ovf_sticky", W'(bs.Ovf), 8'h01);
        bs.ClrOvf = 1'b1;
        tick();
        idle_in();
        chk("clr_s", W'(bs.Ovf), 8'h00);
        chk("clr_w", W'(bw.Ovf), 8'h00);
        bs.RegData = 8'h01;
        bs.UseACC  = 1'b1;
        bs.WE      = 1'b1;
        bs.ClrOvf  = 1'b1;
        tick();
        idle_in();
        chk("setclr_s", W'(bs.Ovf), 8'h01);
        chk("setclr_acc_w", bw.ACC, 8'h81);
        chk("setclr_w", W'(bw.Ovf), 8'h00);
        bs.ClrOvf = 1'b1;
        tick();
        idle_in();
        chk("clr2_s", W'(bs.Ovf), 8'h00);

        // Multiply overflow: 127*127 >>> 3 = 2016.
        mul("m_sat", 8'h7F, 8'h7F, 8'h7F, 8'hE0, 1'b1, 1'b1, 1'b0);
        // WE and Imm changes during MUL are ignored.
        mul("m_dist", 8'h10, 8'h0C, 8'h18, 8'h18, 1'b1, 1'b1, 1'b1);

        // Reset in the 4th busy cycle.
        load(8'h10);
        bs.UseACC = 1'b1;
        bs.UseMul = 1'b1;
        bs.Imm    = 8'h0C;
        bs.WE     = 1'b1;
        tick();
        idle_in();
        tick();
        tick();
        tick();
        chk("mid_busy", W'(bs.Busy), 8'h01);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_rst_acc", bs.ACC, 8'h00);
        chk("mid_rst_busy", W'(bs.Busy), 8'h00);
        chk("mid_rst_done", W'(bs.Done), 8'h00);
        chk("mid_rst_ovf", W'(bs.Ovf), 8'h00);
        tick();
        Reset = 1'b0;
        tick();
        load(8'h21);
        chk("post_acc", bs.ACC, 8'h21);
        chk("post_done", W'(bs.Done), 8'h01);
        chk("post_busy", W'(bs.Busy), 8'h00);
        tick();
        chk("post_done_pulse", W'(bs.Done), 8'h00);
        chk("post_idle_busy", W'(bs.Busy), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
